// File: rtl/aes_pipe_core_if.sv
// aes_pipe_core_if: plaintext-in / ciphertext-out handshake bundle for aes_pipe_core.
// The core attaches through the slave modport; the block feeding and draining it uses master.
interface aes_pipe_core_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/aes_pipe_core.sv
// aes_pipe_core: three-slot recirculating AES encryptor; A=SubBytes, B=ShiftRows(+MixColumns), C=AddRoundKey.
// Round keys come from an external synchronous store addressed by slot B's round index.
module aes_pipe_core #(
  parameter int KEY_BITS = 128,
  parameter int TAG_W    = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           flush,
  aes_pipe_core_if.slave io,
  input  logic [127:0]   round_key_0,
  output logic [3:0]     rk_addr,
  input  logic [127:0]   rk_data,
  output logic           busy
);
  localparam logic [3:0] NR = KEY_BITS == 128 ? 4'd10 : KEY_BITS == 192 ? 4'd12 : 4'd14;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_pipe_core: KEY_BITS must be 128, 192 or 256");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as field inverse (a^254, which maps 0 to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, q;
    p = a;
    q = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      q = gmul(q, p);
    end
    return q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[127-8*((i + 4*(i % 4)) % 16) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  logic             r_va, r_vb, r_vc, r_c_keyed, r_ov;
  logic [127:0]     r_a_blk, r_b_blk, r_c_blk, r_od;
  logic [TAG_W-1:0] r_a_tag, r_b_tag, r_c_tag, r_ot;
  logic [3:0]       r_a_r, r_b_r, r_c_r;
  logic [127:0]     w_c_out, w_b_out, w_a_in;
  logic [TAG_W-1:0] w_a_tag;
  logic [3:0]       w_a_r;
  logic             w_c_fin, w_recirc, w_stall, w_acc;

  // A finished block held in C across a stall absorbs its last round key once (r_c_keyed),
  // because rk_data follows slot B's index while the ring is frozen.
  always_comb begin
    w_c_out  = r_c_keyed ? r_c_blk : r_c_blk ^ rk_data;
    w_c_fin  = r_vc && r_c_r == NR;
    w_recirc = r_vc && r_c_r < NR;
    w_stall  = r_ov && !io.out_ready && w_c_fin;
    w_acc    = io.in_valid && !w_stall && !flush && !w_recirc;
    w_b_out  = r_b_r < NR ? mix_columns(shift_rows(r_b_blk)) : shift_rows(r_b_blk);
    w_a_in   = w_recirc ? w_c_out : w_acc ? io.in_data ^ round_key_0 : '0;
    w_a_tag  = w_recirc ? r_c_tag : w_acc ? io.in_tag : '0;
    w_a_r    = w_recirc ? r_c_r + 4'd1 : w_acc ? 4'd1 : 4'd0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      {r_va, r_vb, r_vc, r_c_keyed, r_ov} <= '0;
      {r_a_blk, r_b_blk, r_c_blk, r_od}   <= '0;
      {r_a_tag, r_b_tag, r_c_tag, r_ot}   <= '0;
      {r_a_r, r_b_r, r_c_r}               <= '0;
    end else if (flush) begin
      {r_va, r_vb, r_vc, r_c_keyed, r_ov} <= '0;
    end else if (w_stall) begin
      r_c_blk   <= w_c_out;
      r_c_keyed <= 1'b1;
    end else begin
      r_va      <= w_recirc || w_acc;
      r_a_blk   <= w_a_in;
      r_a_tag   <= w_a_tag;
      r_a_r     <= w_a_r;
      r_vb      <= r_va;
      r_b_blk   <= sub_bytes(r_a_blk);
      r_b_tag   <= r_a_tag;
      r_b_r     <= r_a_r;
      r_vc      <= r_vb;
      r_c_blk   <= w_b_out;
      r_c_tag   <= r_b_tag;
      r_c_r     <= r_b_r;
      r_c_keyed <= 1'b0;
      r_ov      <= w_c_fin || (r_ov && !io.out_ready);
      if (w_c_fin) begin
        r_od <= w_c_out;
        r_ot <= r_c_tag;
      end
    end
  end

  assign io.in_ready  = !w_stall && !flush && !w_recirc;
  assign io.out_valid = r_ov;
  assign io.out_data  = r_od;
  assign io.out_tag   = r_ot;
  assign rk_addr      = r_vb ? r_b_r : 4'd0;
  assign busy         = r_va || r_vb || r_vc || r_ov;
endmodule

// File: tb/tb_aes_pipe_core.sv
// tb_aes_pipe_core: directed bench for AES-128/192/256 cores fed by a behavioural key store.
// Instance 0 (AES-128) also has a scoreboard built from an independent table-driven AES model.
module tb_aes_pipe_core;
  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0, n_rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0]         in_data = '0;
  logic [3:0]           in_tag = '0;
  logic [127:0]         rks [3][15];
  logic [2:0]           ov, ir, bz;
  logic [2:0][127:0]    od;
  logic [2:0][3:0]      ot, ra;
  int total = 0, bad = 0, nout = 0;
  typedef struct { logic [127:0] d; logic [3:0] t; } exp_t;
  exp_t exq [$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    aes_pipe_core_if #(.TAG_W(4)) bus ();
    logic [127:0] rkd;
    logic [3:0]   addr;
    logic         busy_w;
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.in_tag    = in_tag;
    assign bus.out_ready = out_ready;
    aes_pipe_core #(.KEY_BITS(128 + 64*k), .TAG_W(4)) dut (
      .clk(clk), .n_rst(n_rst), .flush(flush), .io(bus), .round_key_0(rks[k][0]),
      .rk_addr(addr), .rk_data(rkd), .busy(busy_w));
    always @(posedge clk) rkd <= rks[k][addr];
    assign ov[k] = bus.out_valid;
    assign ir[k] = bus.in_ready;
    assign od[k] = bus.out_data;
    assign ot[k] = bus.out_tag;
    assign ra[k] = addr;
    assign bz[k] = busy_w;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sb(input logic [7:0] a);
    return SB[2047-8*int'(a) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[k][0][127-8*i -: 8];
    for (int r = 1; r <= 10 + 2*k; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb(s[(i + 4*(i % 4)) % 16]);
      for (int c = 0; c < 4; c++) begin
        if (r < 10 + 2*k) begin
          s[4*c]   = xt(t[4*c] ^ t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = xt(t[4*c+1] ^ t[4*c+2]) ^ t[4*c] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = xt(t[4*c+2] ^ t[4*c+3]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c+3] ^ t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2];
        end else for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[k][r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // scoreboard for instance 0: record acceptances, check completions in order
  always begin
    exp_t e;
    @(negedge clk);
    if (!n_rst || flush) exq.delete();
    else begin
      if (ov[0] && out_ready) begin
        if (exq.size() == 0) chk("unexpected_out", 128'(ov[0]), 128'd0);
        else begin
          e = exq.pop_front();
          chk("out_data", od[0], e.d);
          chk("out_tag", 128'(ot[0]), 128'(e.t));
        end
        nout++;
      end
      if (in_valid && ir[0]) exq.push_back('{aes_ref(in_data, 0), in_tag});
    end
  end

  task automatic run_one(input logic [3:0] tg, input string nm);
    int lat;
    logic [127:0] d;
    lat = 0;
    d = '0;
    chk({nm, "_ready"}, 128'(ir[0]), 128'd1);
    in_valid = 1'b1;
    in_data = PT;
    in_tag = tg;
    tick();
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (lat == 0 && ov[0]) begin
        lat = n;
        d = od[0];
      end
    end
    chk({nm, "_lat"}, 128'(lat), 128'd30);
    chk({nm, "_data"}, d, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
  endtask

  initial begin
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    int           lat [3];
    logic [127:0] cd [3];
    logic [127:0] want [3];
    int           nacc, n0;
    logic         a;
    logic [3:0]   ra0;
    logic [127:0] d0;
    for (int k = 0; k < 3; k++) begin
      rc = 8'h01;
      for (int i = 0; i < 60; i++) begin
        if (i < 4 + 2*k) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        else begin
          t = w[i-1];
          if (i % (4 + 2*k) == 0) begin
            t = {sb(t[23:16]) ^ rc, sb(t[15:8]), sb(t[7:0]), sb(t[31:24])};
            rc = xt(rc);
          end else if (k == 2 && i % 8 == 4) t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
          w[i] = w[i-4-2*k] ^ t;
        end
      end
      for (int r = 0; r < 15; r++) rks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    want[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    want[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    want[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    repeat (2) tick();
    chk("rst_busy", 128'(bz), 128'd0);
    n_rst = 1'b1;
    chk("rst_out_valid", 128'(ov), 128'd0);
    chk("rst_out_data", od[0], 128'd0);
    chk("rst_out_tag", 128'(ot[0]), 128'd0);
    chk("rst_rk_addr", 128'(ra[0]), 128'd0);
    chk("rst_in_ready", 128'(ir), 128'd7);
    // FIPS-197 vectors on all three key lengths
    in_valid = 1'b1;
    in_data = PT;
    in_tag = 4'h5;
    tick();
    in_valid = 1'b0;
    chk("busy_running", 128'(bz), 128'd7);
    for (int k = 0; k < 3; k++) lat[k] = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      for (int k = 0; k < 3; k++)
        if (lat[k] == 0 && ov[k]) begin
          lat[k] = n;
          cd[k] = od[k];
        end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lat_%0d", 128 + 64*k), 128'(lat[k]), 128'(30 + 6*k));
      chk($sformatf("fips_%0d", 128 + 64*k), cd[k], want[k]);
    end
    // five blocks offered back to back
    n0 = nout;
    nacc = 0;
    for (int n = 0; n < 200 && (nacc < 5 || nout - n0 < 5); n++) begin
      in_valid = nacc < 5;
      in_data = PT ^ {4{32'(nacc) * 32'h9e3779b9}};
      in_tag = 4'(nacc);
      if (n == 3 || n == 15) chk($sformatf("recirc_ready_%0d", n), 128'(ir[0]), 128'd0);
      a = in_valid && ir[0];
      tick();
      if (a) nacc++;
      if (n == 2) chk("burst_accept3", 128'(nacc), 128'd3);
    end
    in_valid = 1'b0;
    chk("burst_outputs", 128'(nout - n0), 128'd5);
    // output backpressure with three blocks finishing
    n0 = nout;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {4{32'h0badcafe + 32'(i)}};
      in_tag = 4'(8 + i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (33) tick();
    chk("stall_out_valid", 128'(ov[0]), 128'd1);
    ra0 = ra[0];
    d0 = od[0];
    repeat (15) tick();
    chk("stall_rk_addr", 128'(ra[0]), 128'(ra0));
    chk("stall_out_data", od[0], d0);
    chk("stall_no_handshake", 128'(nout - n0), 128'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("release_count", 128'(nout - n0), 128'd3);
    chk("release_drained", 128'(ov[0]), 128'd0);
    // flush with two blocks in flight
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n0 = nout;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 128'(ir[0]), 128'd0);
    tick();
    flush = 1'b0;
    chk("flush_busy", 128'(bz[0]), 128'd0);
    chk("flush_out_valid", 128'(ov[0]), 128'd0);
    repeat (40) tick();
    chk("flush_no_output", 128'(nout - n0), 128'd0);
    run_one(4'h3, "after_flush");
    // asynchronous reset in the middle of a block
    in_valid = 1'b1;
    in_data = PT;
    in_tag = 4'h7;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_busy", 128'(bz[0]), 128'd0);
    chk("arst_out_valid", 128'(ov[0]), 128'd0);
    chk("arst_out_data", od[0], 128'd0);
    chk("arst_rk_addr", 128'(ra[0]), 128'd0);
    repeat (2) tick();
    n_rst = 1'b1;
    n0 = nout;
    run_one(4'h9, "after_reset");
    chk("after_reset_count", 128'(nout - n0), 128'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
